add_subt_arbiter: RTL and testbench

//  - Shares one floating-point add/subtract unit between N_REQ requesters (CORDIC FSM, scaling/normalisation logic, ...).
//  - Each requester sees the same beg/ready/ack handshake the add/subt unit itself presents.
//  - Round-robin grant; operands latched at grant; result held until the requester acks.
//  - Sits between the CORDIC control FSMs and the single add_subt datapath instance.

---
 rtl/cordic_ctrl_pkg.sv | 26 ++
 rtl/add_subt_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 39 +++
 rtl/add_subt_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_add_subt_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC control slice: the arbiter state
// encoding, the add/subtract op codes and the round-robin pointer helper.
package cordic_ctrl_pkg;

  localparam int GNT_ID_W = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_RDY = 3'd2,
    DONE     = 3'd3,
    RELEASE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } au_op_e;

  // Pointer to the requester after 'id', wrapping at n.
  function automatic logic [GNT_ID_W-1:0] rr_next(input logic [GNT_ID_W-1:0] id,
                                                  input int n);
    return (int'(id) == n - 1) ? '0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/add_subt_arbiter_if.sv
// Bundle of requester-side and unit-side signals of the add/subt arbiter.
// master: the arbiter itself; slave: requesters plus the add/subt unit.
interface add_subt_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 32
);
  logic [N_REQ-1:0]   req_beg;
  logic [N_REQ-1:0]   req_op;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       result;
  logic [2:0]         gnt_id;
  logic               busy;
  logic               au_beg;
  logic               au_op;
  logic [W-1:0]       au_a;
  logic [W-1:0]       au_b;
  logic               au_ready;
  logic [W-1:0]       au_result;
  logic               au_ack;
  logic               err_timeout;

  modport master (
    input  req_beg, req_op, req_a, req_b, req_ack, au_ready, au_result,
    output req_ready, result, gnt_id, busy, au_beg, au_op, au_a, au_b,
           au_ack, err_timeout
  );

  modport slave (
    output req_beg, req_op, req_a, req_b, req_ack, au_ready, au_result,
    input  req_ready, result, gnt_id, busy, au_beg, au_op, au_a, au_b,
           au_ack, err_timeout
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first active request at or after
// the pointer, wrapping. Outputs one-hot grant, its index and "any".
module rr_pick
  import cordic_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]    req_i,
  input  logic [GNT_ID_W-1:0] ptr_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [GNT_ID_W-1:0] idx_o,
  output logic                any_o
);

  logic [N_REQ-1:0] rot;
  logic             found;
  logic [3:0]       sum;

  // Rotate requests so the pointer sits at bit 0, find the first set bit,
  // then map the offset back to an absolute requester index.
  always_comb begin
    rot   = N_REQ'({req_i, req_i} >> ptr_i);
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + 4'(k);
      end
    end
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    idx_o = sum[GNT_ID_W-1:0];
    gnt_o = '0;
    for (int i = 0; i < N_REQ; i++) gnt_o[i] = found && (idx_o == 3'(i));
  end

  assign any_o = |req_i;

endmodule

// File: rtl/add_subt_arbiter.sv
// Shares one floating-point add/subtract unit between N_REQ requesters.
// Round-robin grant, operands latched at grant, result held until the
// granted requester acknowledges.
// Optional feature macro: ARB_TIMEOUT_EN (WAIT_RDY watchdog, sticky
// err_timeout, result forced to 0 on expiry).
module add_subt_arbiter
  import cordic_ctrl_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  add_subt_arbiter_if.master bus
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("add_subt_arbiter: unsupported parameter set");
  end

  arb_state_e          state_q, state_d;
  logic [GNT_ID_W-1:0] ptr_q, ptr_d;
  logic [GNT_ID_W-1:0] gnt_id_q, gnt_id_d;
  logic                op_q, op_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        result_q, result_d;

  logic [N_REQ-1:0]    pick_gnt;
  logic [GNT_ID_W-1:0] pick_idx;
  logic                pick_any;
  logic                sel_op;
  logic [W-1:0]        sel_a, sel_b;
  logic                ack_sel;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (bus.req_beg),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Operand mux driven by the one-hot pick; only consumed in IDLE.
  always_comb begin
    sel_op = 1'b0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_op = bus.req_op[i];
        sel_a  = bus.req_a[i*W +: W];
        sel_b  = bus.req_b[i*W +: W];
      end
    end
  end

  // Acknowledge of the granted requester only; others are ignored.
  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id_q == 3'(i)) ack_sel = bus.req_ack[i];
    end
  end

  // Next-state and datapath-latch logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = '0;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          gnt_id_d = pick_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // A zero-wait unit may answer in the same cycle as au_beg.
        if (bus.au_ready) begin
          result_d = bus.au_result;
          state_d  = DONE;
        end else begin
          state_d  = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.au_ready) begin
          result_d = bus.au_result;
          state_d  = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (ack_sel) state_d = RELEASE;
      end
      RELEASE: begin
        ptr_d   = rr_next(gnt_id_q, N_REQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and latched operands/result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  // Ready to the granted requester; reset drops it within the same cycle.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = (state_q == DONE) && (gnt_id_q == 3'(i)) && !reset;
    end
  end

  assign bus.au_beg = (state_q == ISSUE) && !reset;
  assign bus.au_ack = (state_q == RELEASE) && !reset;
  assign bus.busy   = (state_q != IDLE);
  assign bus.result = result_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.au_op  = op_q;
  assign bus.au_a   = a_q;
  assign bus.au_b   = b_q;

endmodule

// File: tb/tb_add_subt_arbiter.sv
// Directed bench for add_subt_arbiter (two requesters, 32-bit operands).
module tb_add_subt_arbiter;
  import cordic_ctrl_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int TCYC = 16;
`else
  localparam int TCYC = 255;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  add_subt_arbiter_if #(.N_REQ(2), .W(32)) bus ();

  add_subt_arbiter #(.N_REQ(2), .W(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with the given unit latency (0 = answer in ISSUE).
  task automatic do_op(input int id, input logic [31:0] exp_a, input logic exp_op,
                       input int lat, input logic [31:0] res);
    logic [1:0] oh;
    oh = 2'(1 << id);
    tick();
    chk("grant_id", 32'(bus.gnt_id), 32'(id));
    chk("au_beg_pulse", 32'(bus.au_beg), 32'd1);
    chk("au_a_latched", bus.au_a, exp_a);
    chk("au_op_latched", 32'(bus.au_op), 32'(exp_op));
    bus.au_result = res;
    if (lat == 0) begin
      bus.au_ready = 1'b1;
      tick();
    end else begin
      tick();
      for (int k = 1; k < lat; k++) tick();
      bus.au_ready = 1'b1;
      tick();
    end
    bus.au_ready = 1'b0;
    chk("req_ready_onehot", 32'(bus.req_ready), 32'(oh));
    chk("result", bus.result, res);
    bus.req_ack = oh;
    tick();
    bus.req_ack = '0;
    chk("au_ack_pulse", 32'(bus.au_ack), 32'd1);
    chk("req_ready_drop", 32'(bus.req_ready), 32'd0);
    tick();
    chk("back_to_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.req_beg   = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ack   = '0;
    bus.au_ready  = 1'b0;
    bus.au_result = '0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_au_beg", 32'(bus.au_beg), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
    reset = 1'b0;

    // 1: single requester, unit answers four cycles after au_beg
    bus.req_a[31:0] = 32'h3F80_0000;
    bus.req_b[31:0] = 32'h4000_0000;
    bus.req_op      = 2'b00;
    bus.req_beg     = 2'b01;
    tick();
    chk("t1_au_beg", 32'(bus.au_beg), 32'd1);
    chk("t1_gnt", 32'(bus.gnt_id), 32'd0);
    chk("t1_au_a", bus.au_a, 32'h3F80_0000);
    chk("t1_au_b", bus.au_b, 32'h4000_0000);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_au_beg_single", 32'(bus.au_beg), 32'd0);
    tick();
    tick();
    tick();
    chk("t1_not_ready_yet", 32'(bus.req_ready), 32'd0);
    bus.au_result = 32'h4040_0000;
    bus.au_ready  = 1'b1;
    tick();
    bus.au_ready  = 1'b0;
    chk("t1_ready", 32'(bus.req_ready), 32'b01);
    chk("t1_result", bus.result, 32'h4040_0000);
    bus.req_beg = 2'b00;
    tick();
    chk("t1_ready_held", 32'(bus.req_ready), 32'b01);
    chk("t1_no_early_ack", 32'(bus.au_ack), 32'd0);
    bus.req_ack = 2'b01;
    tick();
    bus.req_ack = 2'b00;
    chk("t1_au_ack", 32'(bus.au_ack), 32'd1);
    tick();
    chk("t1_au_ack_single", 32'(bus.au_ack), 32'd0);
    chk("t1_idle", 32'(bus.busy), 32'd0);
    chk("t1_ptr", 32'(dut.ptr_q), 32'd1);

    // 2: both requesting from reset -> 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t2_ptr_rst", 32'(dut.ptr_q), 32'd0);
    bus.req_a[31:0]  = 32'h1111_1111;
    bus.req_a[63:32] = 32'h2222_2222;
    bus.req_op       = 2'b10;
    bus.req_beg      = 2'b11;
    do_op(0, 32'h1111_1111, 1'b0, 1, 32'hA000_0001);
    do_op(1, 32'h2222_2222, 1'b1, 1, 32'hA000_0002);
    do_op(0, 32'h1111_1111, 1'b0, 1, 32'hA000_0003);
    do_op(1, 32'h2222_2222, 1'b1, 1, 32'hA000_0004);
    bus.req_beg = 2'b00;
    chk("t2_ptr_wrap", 32'(dut.ptr_q), 32'd0);

    // 3: operand change and stray ack mid-operation
    bus.req_beg = 2'b10;
    tick();
    chk("t3_gnt", 32'(bus.gnt_id), 32'd1);
    tick();
    bus.req_a[63:32] = 32'hDEAD_BEEF;
    bus.req_ack      = 2'b01;
    tick();
    bus.req_ack      = 2'b00;
    chk("t3_au_a_stable", bus.au_a, 32'h2222_2222);
    chk("t3_state_wait", 32'(dut.state_q), 32'(WAIT_RDY));
    chk("t3_no_ready", 32'(bus.req_ready), 32'd0);
    bus.au_result = 32'h4120_0000;
    bus.au_ready  = 1'b1;
    tick();
    bus.au_ready  = 1'b0;
    chk("t3_ready", 32'(bus.req_ready), 32'b10);
    bus.req_ack = 2'b01;
    tick();
    bus.req_ack = 2'b00;
    chk("t3_state_done", 32'(dut.state_q), 32'(DONE));
    chk("t3_no_au_ack", 32'(bus.au_ack), 32'd0);
    chk("t3_ready_held", 32'(bus.req_ready), 32'b10);
    bus.req_ack = 2'b10;
    tick();
    bus.req_ack = 2'b00;
    chk("t3_au_ack", 32'(bus.au_ack), 32'd1);
    bus.req_beg = 2'b00;
    bus.req_a[63:32] = 32'h2222_2222;
    tick();
    chk("t3_ptr", 32'(dut.ptr_q), 32'd0);

    // Stray au_ready while idle is ignored
    bus.au_ready = 1'b1;
    tick();
    bus.au_ready = 1'b0;
    chk("idle_au_ready_ignored", 32'(bus.busy), 32'd0);

    // 4: zero-wait unit, then no duplicate result
    bus.req_beg = 2'b01;
    do_op(0, 32'h1111_1111, 1'b0, 0, 32'hC0A0_0000);
    bus.req_beg = 2'b00;
    tick();
    chk("t4_no_dup_busy", 32'(bus.busy), 32'd0);
    chk("t4_no_dup_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_ptr", 32'(dut.ptr_q), 32'd1);

    // 5: reset during WAIT_RDY, then normal service
    bus.req_beg = 2'b10;
    tick();
    tick();
    tick();
    chk("t5_in_wait", 32'(dut.state_q), 32'(WAIT_RDY));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_au_a", bus.au_a, 32'd0);
    chk("t5_result", bus.result, 32'd0);
    chk("t5_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("t5_ptr", 32'(dut.ptr_q), 32'd0);
    do_op(1, 32'h2222_2222, 1'b1, 2, 32'h3F00_0000);

    // Reset in DONE drops req_ready within the same cycle
    bus.req_beg = 2'b01;
    tick();
    bus.au_result = 32'h4100_0000;
    bus.au_ready  = 1'b1;
    tick();
    bus.au_ready  = 1'b0;
    chk("rst_done_pre", 32'(bus.req_ready), 32'b01);
    reset = 1'b1;
    #1;
    chk("rst_done_same_cycle", 32'(bus.req_ready), 32'd0);
    bus.req_beg = 2'b00;
    tick();
    reset = 1'b0;
    chk("rst_done_idle", 32'(bus.busy), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // 6: watchdog expiry after 16 WAIT_RDY cycles
    bus.req_beg = 2'b01;
    do_op(0, 32'h1111_1111, 1'b0, 1, 32'h1234_5678);
    bus.req_beg = 2'b10;
    tick();
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("t6_still_wait", 32'(dut.state_q), 32'(WAIT_RDY));
    chk("t6_err_not_yet", 32'(bus.err_timeout), 32'd0);
    tick();
    bus.req_beg = 2'b00;
    chk("t6_err", 32'(bus.err_timeout), 32'd1);
    chk("t6_result_zero", bus.result, 32'd0);
    chk("t6_ready", 32'(bus.req_ready), 32'b10);
    bus.req_ack = 2'b10;
    tick();
    bus.req_ack = 2'b00;
    chk("t6_au_ack", 32'(bus.au_ack), 32'd1);
    tick();
    chk("t6_idle", 32'(bus.busy), 32'd0);
    chk("t6_err_sticky", 32'(bus.err_timeout), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_err_cleared", 32'(bus.err_timeout), 32'd0);
`else
    chk("err_tied_low", 32'(bus.err_timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
